// File: rtl/micro_painter_pkg.sv
// Shared types and quadrature decode helpers for the microPainter encoder front end.
// Combinational only; no latency.
// No flow control; pure definitions.
package micro_painter_pkg;

    typedef enum logic {DIR_REV = 1'b0, DIR_FWD = 1'b1} dir_t;

    // Forward Gray successor of each {A,B} state, indexed by that state:
    // 00->10, 01->00, 10->11, 11->01 (A leads B when counting up).
    localparam logic [3:0][1:0] QUAD_FWD_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};

    typedef struct packed {
        logic illegal;
        logic valid;
        logic up;
    } quad_delta_t;

    // Classify one transition of the filtered {A,B} pair.
    function automatic quad_delta_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
        quad_delta_t d;
        d.illegal = ((prev ^ cur) == 2'b11);
        d.up      = (cur == QUAD_FWD_NEXT[prev]);
        d.valid   = d.up || (prev == QUAD_FWD_NEXT[cur]);
        return d;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-flop sync, stability filter, 4x decode, position, column phase, sticky err.
// Latency: raw pin edge to step is 2 + FILTER_CYC + 1 clocks; filtered change to step is 1 clock.
// No backpressure; every accepted count is reported immediately.
module quad_channel
    import micro_painter_pkg::*;
#(
    parameter int POS_W      = 16,
    parameter int FILTER_CYC = 4,
    parameter int COL_DIV    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             zero,
    input  logic             clear_err,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             col_strobe,
    output logic             col_dir,
    output logic             err
);

    localparam int CW = (FILTER_CYC > 0) ? $clog2(FILTER_CYC + 1) : 1;
    localparam int PW = (COL_DIV > 1) ? $clog2(COL_DIV) : 1;
    localparam logic [CW-1:0] FILT_LAST  = CW'((FILTER_CYC > 0) ? FILTER_CYC - 1 : 0);
    localparam logic [PW-1:0] PHASE_LAST = PW'(COL_DIV - 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    cur;
    logic [1:0]    prev;
    logic [1:0]    arm_cnt;
    logic          armed;
    logic [PW-1:0] phase;
    dir_t          dir_q;
    quad_delta_t   delta;

    // Two-flop synchroniser on the {A,B} pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {a_raw, b_raw};
            sync2 <= sync1;
        end
    end

    // Arm counter: the first three clocks after reset only track the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) arm_cnt <= 2'd0;
        else if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end

    assign armed = (arm_cnt == 2'd3);

    generate
        if (FILTER_CYC == 0) begin : g_bypass
            assign cur = sync2;
        end else begin : g_filter
            for (genvar p = 0; p < 2; p++) begin : g_pin
                logic [CW-1:0] cnt;
                logic          filt;
                // Accept a pin change only after FILTER_CYC consecutive differing clocks.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        cnt  <= '0;
                        filt <= 1'b0;
                    end else if (!armed) begin
                        cnt  <= '0;
                        filt <= sync2[p];
                    end else if (sync2[p] == filt) begin
                        cnt <= '0;
                    end else if (cnt == FILT_LAST) begin
                        cnt  <= '0;
                        filt <= sync2[p];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                assign cur[p] = filt;
            end
        end
    endgenerate

    assign delta = quad_delta(prev, cur);

    // Decode, position, column phase and sticky error; zero beats a step, err set beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev       <= 2'b00;
            pos        <= '0;
            phase      <= '0;
            step       <= 1'b0;
            dir_q      <= DIR_REV;
            col_strobe <= 1'b0;
            col_dir    <= 1'b0;
            err        <= 1'b0;
        end else begin
            // While arming, prev follows the synced pins so the first armed compare is clean.
            prev       <= armed ? cur : sync2;
            step       <= armed && delta.valid;
            col_strobe <= 1'b0;
            col_dir    <= 1'b0;
            if (armed && delta.valid) dir_q <= delta.up ? DIR_FWD : DIR_REV;
            if (armed && delta.illegal) err <= 1'b1;
            else if (clear_err) err <= 1'b0;
            if (zero) begin
                pos   <= '0;
                phase <= '0;
            end else if (armed && delta.valid) begin
                if (delta.up) begin
                    pos <= pos + 1'b1;
                    if (phase == PHASE_LAST) begin
                        phase      <= '0;
                        col_strobe <= 1'b1;
                        col_dir    <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end else begin
                    pos <= pos - 1'b1;
                    if (phase == '0) begin
                        phase      <= PHASE_LAST;
                        col_strobe <= 1'b1;
                        col_dir    <= 1'b0;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
            end
        end
    end

    assign dir = dir_q;

endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder front end; one independent quad_channel per encoder.
// Latency: raw pin edge to step is 2 + FILTER_CYC + 1 clocks.
// No backpressure; outputs are pulses and levels, channels share no state.
module quad_encoder_array
    import micro_painter_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int POS_W      = 16,
    parameter int FILTER_CYC = 4,
    parameter int COL_DIV    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a_raw,
    input  logic [N_CH-1:0]       b_raw,
    input  logic [N_CH-1:0]       zero,
    input  logic [N_CH-1:0]       clear_err,
    output logic [N_CH*POS_W-1:0] pos,
    output logic [N_CH-1:0]       step,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       col_strobe,
    output logic [N_CH-1:0]       col_dir,
    output logic [N_CH-1:0]       err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        quad_channel #(
            .POS_W      (POS_W),
            .FILTER_CYC (FILTER_CYC),
            .COL_DIV    (COL_DIV)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .a_raw      (a_raw[i]),
            .b_raw      (b_raw[i]),
            .zero       (zero[i]),
            .clear_err  (clear_err[i]),
            .pos        (pos[i*POS_W +: POS_W]),
            .step       (step[i]),
            .dir        (dir[i]),
            .col_strobe (col_strobe[i]),
            .col_dir    (col_dir[i]),
            .err        (err[i])
        );
    end

endmodule
